instruction_fetch: RTL and testbench

Fetch stage of the MIPS pipeline, directly upstream of the byte-addressed, big-endian, combinational-read instruction memory. It owns the program counter, drives the memory address, captures the returned word into the IF/ID pipeline register, and applies stalls from decode and redirects (branch/jump) from later stages. Range and alignment errors stop fetching until reset.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_pc_sel.sv | 53 +++++
 rtl/instruction_fetch.sv | 121 ++++++++++++
 tb/tb_instruction_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP            = 32'h0000_0000;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  typedef enum logic {StRun, StHalt} fetch_state_e;

  // A wrapped sum arrives with bit 32 set and is rejected along with misaligned
  // or out-of-range addresses.
  function automatic logic addr_legal(input logic [32:0] a, input int unsigned mem_bytes);
    return (a[32] == 1'b0) && (a[1:0] == 2'b00) && (a[31:0] <= (mem_bytes - 32'd4));
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selection for the fetch stage: redirect, sequential advance or hold,
// plus detection of illegal fetch addresses.
module fetch_pc_sel
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic [31:0]  pc_i,
  input  logic         redirect_valid_i,
  input  logic [31:0]  redirect_target_i,
  input  logic         advance_i,
  input  fetch_state_e state_i,
  output logic [31:0]  next_pc_o,
  output logic [31:0]  pc_plus4_o,
  output logic         flush_o,
  output logic         error_o,
  output logic [31:0]  err_addr_o
);

  logic [32:0] pc_sum;

  assign pc_sum     = {1'b0, pc_i} + 33'd4;
  assign pc_plus4_o = pc_sum[31:0];

  always_comb begin
    next_pc_o  = pc_i;
    flush_o    = 1'b0;
    error_o    = 1'b0;
    err_addr_o = 32'h0;
    if (state_i == StRun) begin
      if (redirect_valid_i) begin
        flush_o = 1'b1;
        if (addr_legal({1'b0, redirect_target_i}, MEM_BYTES)) begin
          next_pc_o = redirect_target_i;
        end else begin
          error_o    = 1'b1;
          err_addr_o = redirect_target_i;
        end
      end else if (advance_i) begin
        if (addr_legal(pc_sum, MEM_BYTES)) begin
          next_pc_o = pc_sum[31:0];
        end else begin
          error_o    = 1'b1;
          err_addr_o = pc_sum[31:0];
        end
      end
    end else begin
      // In HALT a redirect only serves to drop the IF/ID entry.
      flush_o = redirect_valid_i;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, drives instruction memory and fills the IF/ID
// register, honouring decode stalls and branch/jump redirects.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DefaultResetPc,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        fetch_err,
  output logic [31:0] err_addr,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_pc4_q, id_pc4_d;
  logic         err_q, err_d;
  logic [31:0]  err_addr_q, err_addr_d;

  logic         advance;
  logic [31:0]  sel_next_pc;
  logic [31:0]  sel_pc_plus4;
  logic         sel_flush;
  logic         sel_error;
  logic [31:0]  sel_err_addr;

  assign advance = !valid_q || id_ready;

  fetch_pc_sel #(
    .MEM_BYTES(MEM_BYTES)
  ) u_pc_sel (
    .pc_i              (pc_q),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .advance_i         (advance),
    .state_i           (state_q),
    .next_pc_o         (sel_next_pc),
    .pc_plus4_o        (sel_pc_plus4),
    .flush_o           (sel_flush),
    .error_o           (sel_error),
    .err_addr_o        (sel_err_addr)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = sel_next_pc;
    valid_d    = valid_q;
    instr_d    = instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    if (sel_error) begin
      state_d    = StHalt;
      err_d      = 1'b1;
      err_addr_d = sel_err_addr;
    end

    if (state_q == StRun) begin
      if (sel_flush) begin
        valid_d = 1'b0;
        instr_d = NOP;
      end else if (advance) begin
        // The word at pc is delivered even when pc+4 is about to fault.
        valid_d  = 1'b1;
        instr_d  = imem_data;
        id_pc_d  = pc_q;
        id_pc4_d = sel_pc_plus4;
      end
    end else if (sel_flush || id_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      id_pc_q    <= 32'h0;
      id_pc4_q   <= 32'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus4 = id_pc4_q;
  assign fetch_err      = err_q;
  assign err_addr       = err_addr_q;
  assign halted         = (state_q == StHalt);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a scoreboard of words decode should accept, plus
// direct checks of stall, redirect, error and reset behaviour.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        fetch_err;
  logic [31:0] err_addr;
  logic        halted;

  logic [31:0] mem [256];
  logic [31:0] exp_q [$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (1024)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .fetch_err       (fetch_err),
    .err_addr        (err_addr),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[9:2]];

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h2008_0001 + (pc >> 2) * 32'h0001_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_valid", {31'h0, if_id_valid}, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pc", if_id_pc, 32'h0);
    check("rst_pc4", if_id_pc_plus4, 32'h0);
    check("rst_err", {31'h0, fetch_err}, 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
  endtask

  // Decode takes the IF/ID entry whenever valid and ready coincide.
  always @(negedge clk) begin
    if (if_id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_accept_pc", if_id_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", if_id_pc, e);
        check("sb_instr", if_id_instr, word_at(e));
        check("sb_pc4", if_id_pc_plus4, e + 32'd4);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = word_at(32'(i) << 2);
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    id_ready        = 1'b0;
    step();
    step();
    check_reset();

    // Sequential fetch, then a three-cycle stall holding pc=8.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    rst_n    = 1'b1;
    id_ready = 1'b1;
    step();
    check("seq_valid", {31'h0, if_id_valid}, 32'h1);
    check("seq_pc0", if_id_pc, 32'h0);
    step();
    step();
    check("seq_pc8", if_id_pc, 32'h8);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", if_id_pc, 32'h8);
      check("stall_instr", if_id_instr, word_at(32'h8));
      check("stall_addr", imem_addr, 32'hC);
      check("stall_valid", {31'h0, if_id_valid}, 32'h1);
    end
    exp_q.push_back(32'hC);
    id_ready = 1'b1;
    step();
    check("resume_pc", if_id_pc, 32'hC);
    check("resume_addr", imem_addr, 32'h10);

    // Redirect to 0x40 while pc=0x10: one bubble.
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    step();
    check("redir_bubble", {31'h0, if_id_valid}, 32'h0);
    check("redir_nop", if_id_instr, 32'h0);
    check("redir_addr", imem_addr, 32'h40);
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    step();
    check("redir_pc", if_id_pc, 32'h40);
    check("redir_instr", if_id_instr, word_at(32'h40));

    // Redirect during a stall still wins.
    redirect_valid  = 1'b1;
    redirect_target = 32'h80;
    step();
    check("stall_redir_valid", {31'h0, if_id_valid}, 32'h0);
    check("stall_redir_addr", imem_addr, 32'h80);
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    exp_q.push_back(32'h80);
    exp_q.push_back(32'h84);
    step();
    step();

    // Misaligned redirect halts fetching.
    redirect_valid  = 1'b1;
    redirect_target = 32'h42;
    step();
    check("mis_err", {31'h0, fetch_err}, 32'h1);
    check("mis_err_addr", err_addr, 32'h42);
    check("mis_halted", {31'h0, halted}, 32'h1);
    check("mis_valid", {31'h0, if_id_valid}, 32'h0);
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_valid", {31'h0, if_id_valid}, 32'h0);
      check("halt_addr", imem_addr, 32'h88);
    end

    // Reset out of HALT, then reset mid-stream against a redirect.
    rst_n = 1'b0;
    step();
    check_reset();
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    step();
    step();
    step();
    rst_n           = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    step();
    check_reset();
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    exp_q.push_back(32'h0);
    step();

    // Out-of-range redirect.
    redirect_valid  = 1'b1;
    redirect_target = 32'h400;
    step();
    check("oor_err", {31'h0, fetch_err}, 32'h1);
    check("oor_err_addr", err_addr, 32'h400);
    check("oor_halted", {31'h0, halted}, 32'h1);
    check("oor_valid", {31'h0, if_id_valid}, 32'h0);
    redirect_valid = 1'b0;
    step();
    check("oor_valid_hold", {31'h0, if_id_valid}, 32'h0);

    // Run off the end of memory.
    rst_n = 1'b0;
    step();
    check_reset();
    rst_n           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h3F0;
    step();
    check("eom_addr", imem_addr, 32'h3F0);
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h3F0 + 32'(i) * 32'd4);
    for (int i = 0; i < 4; i++) step();
    check("eom_valid", {31'h0, if_id_valid}, 32'h1);
    check("eom_pc", if_id_pc, 32'h3FC);
    check("eom_err", {31'h0, fetch_err}, 32'h1);
    check("eom_err_addr", err_addr, 32'h400);
    check("eom_halted", {31'h0, halted}, 32'h1);
    check("eom_imem_addr", imem_addr, 32'h3FC);
    step();
    check("eom_drain", {31'h0, if_id_valid}, 32'h0);
    step();
    step();
    check("eom_still_empty", {31'h0, if_id_valid}, 32'h0);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
